// File: rtl/fifo_wr_arbiter_if.sv
// Requester/FIFO-side bundle for the write-port arbiter.
// The slave modport is the arbiter's view. The master modport is the view of
// the requesters plus the FIFO write port that drive and observe it.
interface fifo_wr_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16
);
    localparam int IDW = (NREQ <= 2) ? 1 : $clog2(NREQ);

    logic [NREQ-1:0]       i_req_valid;
    logic [NREQ-1:0]       i_req_last;
    logic [NREQ*WIDTH-1:0] i_req_data;
    logic [NREQ-1:0]       o_req_ready;
    logic                  i_full;
    logic                  o_push;
    logic [WIDTH+IDW-1:0]  o_wdata;
    logic [IDW-1:0]        o_grant_id;
    logic                  o_busy;

    modport slave (
        input  i_req_valid, i_req_last, i_req_data, i_full,
        output o_req_ready, o_push, o_wdata, o_grant_id, o_busy
    );

    modport master (
        output i_req_valid, i_req_last, i_req_data, i_full,
        input  o_req_ready, o_push, o_wdata, o_grant_id, o_busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NREQ requesters.
// A grant is held for a whole packet, or until MAX_BURST beats have been pushed.
// Each grant is followed by one IDLE cycle, and arbitration happens in that cycle.
module fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int WIDTH     = 16,
    parameter int MAX_BURST = 4
) (
    input  logic              i_wclk,
    input  logic              i_wrst_n,
    fifo_wr_arbiter_if.slave  bus
);
    localparam int IDW  = (NREQ <= 2) ? 1 : $clog2(NREQ);
    localparam int CNTW = $clog2(MAX_BURST + 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    logic [0:0]      state_q,    state_d;
    logic [IDW-1:0]  grant_id_q, grant_id_d;
    logic [IDW-1:0]  last_id_q,  last_id_d;
    logic [CNTW-1:0] cnt_q,      cnt_d;

    logic            found;
    logic [IDW-1:0]  winner;
    logic            sel_valid;
    logic            sel_last;
    logic [WIDTH-1:0] sel_data;
    logic            granted;
    logic            push;
    logic            release_grant;
    logic [NREQ-1:0] ready_vec;

    assign granted = (state_q == ST_GRANT);

    // Round-robin search: first look above last_id, then wrap to the low indices.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && bus.i_req_valid[k] && (IDW'(k) > last_id_q)) begin
                found  = 1'b1;
                winner = IDW'(k);
            end
        end
        for (int k = 0; k < NREQ; k++) begin
            if (!found && bus.i_req_valid[k]) begin
                found  = 1'b1;
                winner = IDW'(k);
            end
        end
    end

    // Mux the granted requester's valid/last/payload onto the write path.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant_id_q == IDW'(k)) begin
                sel_valid = bus.i_req_valid[k];
                sel_last  = bus.i_req_last[k];
                sel_data  = bus.i_req_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // Only the owner sees ready, and only while the FIFO has room.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
            assign ready_vec[gi] = granted && (grant_id_q == IDW'(gi)) && !bus.i_full;
        end
    endgenerate

    assign push          = granted && sel_valid && !bus.i_full;
    assign release_grant = push && (sel_last || ((cnt_q + CNTW'(1)) == CNTW'(MAX_BURST)));

    assign bus.o_req_ready = ready_vec;
    assign bus.o_push      = push;
    assign bus.o_busy      = granted;
    assign bus.o_grant_id  = granted ? grant_id_q : '0;
    assign bus.o_wdata     = granted ? {grant_id_q, sel_data} : '0;

    // Next-state logic: grant in IDLE, count beats and release in GRANT.
    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        last_id_d  = last_id_q;
        cnt_d      = cnt_q;
        if (state_q == ST_IDLE) begin
            if (found) begin
                state_d    = ST_GRANT;
                grant_id_d = winner;
                last_id_d  = winner;
                cnt_d      = '0;
            end
        end else begin
            if (push) begin
                cnt_d = cnt_q + CNTW'(1);
            end
            if (release_grant) begin
                state_d = ST_IDLE;
            end
        end
    end

    // State registers. Reset drops any grant at once, and requester 0 gets first priority.
    always_ff @(posedge i_wclk or negedge i_wrst_n) begin
        if (!i_wrst_n) begin
            state_q    <= ST_IDLE;
            grant_id_q <= '0;
            last_id_q  <= IDW'(NREQ - 1);
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            last_id_q  <= last_id_d;
            cnt_q      <= cnt_d;
        end
    end
endmodule
